// File: rtl/lfsr_delay_ctrl.sv
// lfsr_delay_ctrl: samples an external LFSR, clamps it to a ms delay, fires once per request.
// Optional macro LFSR_FREERUN_EN keeps lfsr_en high in every state.
module lfsr_delay_ctrl #(
  parameter int WIDTH     = 14,
  parameter int MIN_DELAY = 250,
  parameter int MAX_DELAY = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             tick_ms,
  input  logic [WIDTH-1:0] lfsr_in,
  output logic             lfsr_en,
  output logic             busy,
  output logic             fire,
  output logic             done,
  output logic [WIDTH-1:0] delay_out
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_DELAY);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_LOAD,
    S_WAIT,
    S_FIRE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] count_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      delay_q <= delay_d;
    end
  end

  always_comb begin
    clamped = lfsr_in;
    if (lfsr_in < MIN_V) clamped = MIN_V;
    else if (lfsr_in > MAX_V) clamped = MAX_V;
  end

  assign count_inc = count_q + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    delay_d = delay_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        state_d = abort ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          delay_d = clamped;
          count_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // abort beats a terminal tick on the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (tick_ms) begin
          count_d = count_inc;
          if (count_inc == delay_q) state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fire      = (state_q == S_FIRE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_SAMPLE) || (state_q == S_LOAD) ||
                     (state_q == S_WAIT)   || (state_q == S_FIRE);
  assign delay_out = delay_q;

`ifdef LFSR_FREERUN_EN
  assign lfsr_en = 1'b1;
`else
  assign lfsr_en = (state_q == S_SAMPLE);
`endif

endmodule

// File: tb/tb_lfsr_delay_ctrl.sv
// Scoreboard bench for lfsr_delay_ctrl: stimulus pushes expected fires, monitor pops on fire.
module tb_lfsr_delay_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        tick_ms;
  logic [13:0] lfsr_in;
  logic        lfsr_en;
  logic        busy;
  logic        fire;
  logic        done;
  logic [13:0] delay_out;

  typedef struct {
    int delay;
    int ticks;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   en_cnt   = 0;
  int   tick_cnt = 0;
  bit   prev_fire = 1'b0;

  lfsr_delay_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .tick_ms   (tick_ms),
    .lfsr_in   (lfsr_in),
    .lfsr_en   (lfsr_en),
    .busy      (busy),
    .fire      (fire),
    .done      (done),
    .delay_out (delay_out)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int x);
    if (x < 250) return 250;
    if (x > 4000) return 4000;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (lfsr_en) en_cnt++;
    if (fire) begin
      chk("fire_width", int'(prev_fire), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire: got fire=1 expected none (delay_out=%0d)",
                 delay_out);
      end else begin
        e = exp_q.pop_front();
        chk("fire_delay_out", int'(delay_out), e.delay);
        chk("fire_tick_count", tick_cnt, e.ticks);
      end
    end
    prev_fire = fire;
  end

  // mode 0: complete, 1: abort on tick stop_at, 2: reset on tick stop_at
  task automatic do_request(input int val, input bit early, input int mode,
                            input int stop_at, input int hold);
    int d;
    int en0;
    int n;
    int w;
    d   = clamp(val);
    en0 = en_cnt;
    start = 1'b1;
    step();
    lfsr_in = 14'($urandom);
    tick_ms = early;
    chk("busy_sample", int'(busy), 1);
    step();
    lfsr_in = 14'(val);
    step();
    lfsr_in = 14'($urandom);
    tick_ms = 1'b0;
    chk("delay_out_load", int'(delay_out), d);
    chk("busy_wait", int'(busy), 1);
    if (mode == 0) exp_q.push_back('{delay: d, ticks: d});
    tick_cnt = 0;
    n = (mode == 0) ? d : stop_at;
    for (int k = 1; k <= n; k++) begin
      tick_ms = 1'b1;
      tick_cnt++;
      if (k == n && mode == 1) abort = 1'b1;
      if (k == n && mode == 2) rst = 1'b1;
      step();
      tick_ms = 1'b0;
      abort   = 1'b0;
      rst     = 1'b0;
      if (k == n && mode != 0) start = 1'b0;
      if (k < n && $urandom_range(0, 3) == 0) step();
    end
    if (mode == 0) begin
      chk("fire_latency", int'(fire), 1);
      w = 0;
      while (!done && w < 10) begin
        step();
        w++;
      end
      chk("done_seen", int'(done), 1);
      repeat (hold) begin
        tick_ms = 1'($urandom);
        step();
      end
      tick_ms = 1'b0;
      chk("done_held", int'(done), 1);
      chk("busy_done", int'(busy), 0);
      start = 1'b0;
      step();
      chk("done_drop", int'(done), 0);
    end else begin
      chk("cancel_busy", int'(busy), 0);
      chk("cancel_done", int'(done), 0);
      chk("cancel_fire", int'(fire), 0);
      if (mode == 2) chk("reset_delay_out", int'(delay_out), 0);
      repeat (20) begin
        tick_ms = 1'b1;
        step();
      end
      tick_ms = 1'b0;
      chk("cancel_idle_done", int'(done), 0);
    end
`ifndef LFSR_FREERUN_EN
    chk("lfsr_en_steps", en_cnt - en0, 1);
`endif
  endtask

  initial begin
    int hi;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    tick_ms = 1'b0;
    lfsr_in = '0;
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fire", int'(fire), 0);
    chk("rst_delay_out", int'(delay_out), 0);
`ifdef LFSR_FREERUN_EN
    chk("rst_lfsr_en", int'(lfsr_en), 1);
`else
    chk("rst_lfsr_en", int'(lfsr_en), 0);
`endif
    rst = 1'b0;
    hi = 0;
    repeat (20) begin
      tick_ms = 1'($urandom);
      step();
      hi += int'(lfsr_en);
    end
    tick_ms = 1'b0;
    chk("idle_busy", int'(busy), 0);
`ifdef LFSR_FREERUN_EN
    chk("idle_lfsr_en_cycles", hi, 20);
`else
    chk("idle_lfsr_en_cycles", hi, 0);
`endif

    do_request(1000, 1'b0, 0, 0, 50);
    do_request(1, 1'b1, 0, 0, 2);
    do_request(16383, 1'b0, 0, 0, 0);
    do_request(250, 1'b1, 0, 0, 3);
    do_request(4000, 1'b0, 0, 0, 1);
    do_request(249, 1'b0, 0, 0, 0);
    do_request(4001, 1'b1, 0, 0, 0);
    do_request(600, 1'b0, 1, 10, 0);
    do_request(300, 1'b0, 1, 300, 0);
    do_request(2000, 1'b0, 2, 100, 0);
    repeat (3) do_request(int'($urandom_range(0, 5000)), 1'($urandom), 0, 0,
                          int'($urandom_range(0, 5)));
    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
